// File: rtl/dp_ram_be_clr.sv
// True dual-port, single-clock block RAM with byte enables, per-port read-during-write mode,
// optional output register, collision flag and a post-reset clear sequencer.
module dp_ram_be_clr #(
  parameter int unsigned       DATA_W       = 16,
  parameter int unsigned       ADDR_W       = 8,
  parameter string             MODE_A       = "WRITE_FIRST",
  parameter string             MODE_B       = "WRITE_FIRST",
  parameter bit                DO_REG       = 1'b0,
  parameter bit                CLR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] SRVAL_A      = '0,
  parameter logic [DATA_W-1:0] SRVAL_B      = '0,
  localparam int unsigned      BE_W         = DATA_W / 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  output logic              BUSY,
  output logic              COLL,
  input  logic              ENA,
  input  logic              RSTA,
  input  logic [BE_W-1:0]   WEA,
  input  logic [ADDR_W-1:0] ADDRA,
  input  logic [DATA_W-1:0] DIA,
  output logic [DATA_W-1:0] DOA,
  input  logic              ENB,
  input  logic              RSTB,
  input  logic [BE_W-1:0]   WEB,
  input  logic [ADDR_W-1:0] ADDRB,
  input  logic [DATA_W-1:0] DIB,
  output logic [DATA_W-1:0] DOB
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam bit A_WF = (MODE_A == "WRITE_FIRST");
  localparam bit A_RF = (MODE_A == "READ_FIRST");
  localparam bit B_WF = (MODE_B == "WRITE_FIRST");
  localparam bit B_RF = (MODE_B == "READ_FIRST");

  typedef enum logic {StIdle, StClear} state_e;

  logic [DATA_W-1:0] r_mem [DEPTH];

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_do1_a, r_do2_a, r_do1_b, r_do2_b;
  logic [DATA_W-1:0] w_do1_a_nxt, w_do2_a_nxt, w_do1_b_nxt, w_do2_b_nxt;
  logic              r_coll, w_coll_nxt;
  logic              w_busy, w_act_a, w_act_b;
  logic [DATA_W-1:0] w_old_a, w_old_b, w_mrg_a, w_mrg_b;

  assign w_busy  = (r_state == StClear);
  assign w_act_a = ENA & ~w_busy;
  assign w_act_b = ENB & ~w_busy;
  assign w_old_a = r_mem[ADDRA];
  assign w_old_b = r_mem[ADDRB];

  // Each port's own view of its write: new enabled bytes over the pre-edge word.
  always_comb begin
    w_mrg_a = w_old_a;
    w_mrg_b = w_old_b;
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (WEA[i]) w_mrg_a[i*8 +: 8] = DIA[i*8 +: 8];
      if (WEB[i]) w_mrg_b[i*8 +: 8] = DIB[i*8 +: 8];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      StClear: begin
        w_cnt_nxt = r_cnt + ADDR_W'(1);
        if (r_cnt == '1) w_state_nxt = StIdle;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_do1_a_nxt = r_do1_a;
    if (w_act_a) begin
      if (RSTA)            w_do1_a_nxt = SRVAL_A;
      else if (WEA == '0)  w_do1_a_nxt = w_old_a;
      else if (A_WF)       w_do1_a_nxt = w_mrg_a;
      else if (A_RF)       w_do1_a_nxt = w_old_a;
    end
    w_do1_b_nxt = r_do1_b;
    if (w_act_b) begin
      if (RSTB)            w_do1_b_nxt = SRVAL_B;
      else if (WEB == '0)  w_do1_b_nxt = w_old_b;
      else if (B_WF)       w_do1_b_nxt = w_mrg_b;
      else if (B_RF)       w_do1_b_nxt = w_old_b;
    end
    w_do2_a_nxt = (w_act_a && RSTA) ? SRVAL_A : r_do1_a;
    w_do2_b_nxt = (w_act_b && RSTB) ? SRVAL_B : r_do1_b;
    w_coll_nxt  = w_act_a & w_act_b & (ADDRA == ADDRB) & ((|WEA) | (|WEB));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= CLR_ON_RESET ? StClear : StIdle;
      r_cnt   <= '0;
      r_do1_a <= SRVAL_A;
      r_do2_a <= SRVAL_A;
      r_do1_b <= SRVAL_B;
      r_do2_b <= SRVAL_B;
      r_coll  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_do1_a <= w_do1_a_nxt;
      r_do2_a <= w_do2_a_nxt;
      r_do1_b <= w_do1_b_nxt;
      r_do2_b <= w_do2_b_nxt;
      r_coll  <= w_coll_nxt;
    end
  end

  // Array has no reset; port A is written last so it wins shared bytes on a collision.
  always_ff @(posedge CLK) begin
    if (w_busy) begin
      r_mem[r_cnt] <= '0;
    end else begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (ENB && WEB[i]) r_mem[ADDRB][i*8 +: 8] <= DIB[i*8 +: 8];
      end
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (ENA && WEA[i]) r_mem[ADDRA][i*8 +: 8] <= DIA[i*8 +: 8];
      end
    end
  end

  assign BUSY = w_busy;
  assign COLL = r_coll;
  assign DOA  = DO_REG ? r_do2_a : r_do1_a;
  assign DOB  = DO_REG ? r_do2_b : r_do1_b;

endmodule

// File: tb/tb_dp_ram_be_clr.sv
// Scoreboard bench: stimulus queues cycle-tagged expectations, a negedge monitor retires them.
module tb_dp_ram_be_clr;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        ENA, RSTA, ENB, RSTB;
  logic [1:0]  WEA, WEB;
  logic [7:0]  ADDRA, ADDRB;
  logic [15:0] DIA, DIB;
  logic [15:0] doa0, dob0, doa1, dob1;
  logic        busy0, coll0, busy1, coll1;

  always #5 CLK = ~CLK;

  // dut0: single-cycle output; dut1: identical but with the output register.
  dp_ram_be_clr #(
    .DATA_W(16), .ADDR_W(8), .MODE_A("WRITE_FIRST"), .MODE_B("READ_FIRST"),
    .DO_REG(1'b0), .CLR_ON_RESET(1'b1), .SRVAL_A(16'h00FF), .SRVAL_B(16'h0000)
  ) dut0 (
    .CLK(CLK), .RST_N(RST_N), .BUSY(busy0), .COLL(coll0),
    .ENA(ENA), .RSTA(RSTA), .WEA(WEA), .ADDRA(ADDRA), .DIA(DIA), .DOA(doa0),
    .ENB(ENB), .RSTB(RSTB), .WEB(WEB), .ADDRB(ADDRB), .DIB(DIB), .DOB(dob0)
  );

  dp_ram_be_clr #(
    .DATA_W(16), .ADDR_W(8), .MODE_A("WRITE_FIRST"), .MODE_B("READ_FIRST"),
    .DO_REG(1'b1), .CLR_ON_RESET(1'b1), .SRVAL_A(16'h00FF), .SRVAL_B(16'h0000)
  ) dut1 (
    .CLK(CLK), .RST_N(RST_N), .BUSY(busy1), .COLL(coll1),
    .ENA(ENA), .RSTA(RSTA), .WEA(WEA), .ADDRA(ADDRA), .DIA(DIA), .DOA(doa1),
    .ENB(ENB), .RSTB(RSTB), .WEB(WEB), .ADDRB(ADDRB), .DIB(DIB), .DOB(dob1)
  );

  localparam int P_DOA = 0, P_DOB = 1, P_COLL = 2, P_BUSY = 3, P_DOA1 = 4;

  typedef struct {
    int          cyc;
    int          port;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [15:0] probe(input int p);
    case (p)
      P_DOA:   return doa0;
      P_DOB:   return dob0;
      P_COLL:  return {15'b0, coll0};
      P_BUSY:  return {15'b0, busy0};
      P_DOA1:  return doa1;
      default: return 16'hxxxx;
    endcase
  endfunction

  always @(negedge CLK) begin
    logic [15:0] act;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        act = probe(q[i].port);
        n_chk = n_chk + 1;
        if (act !== q[i].exp || q[i].cyc != cyc) begin
          n_fail = n_fail + 1;
          $display("FAIL %s: got %h, required %h (due cycle %0d, seen cycle %0d)",
                   q[i].name, act, q[i].exp, q[i].cyc, cyc);
        end
        q.delete(i);
      end
    end
  end

  task automatic expect_v(input int port, input logic [15:0] v, input int lat,
                          input string nm);
    exp_t e;
    e.cyc  = cyc + lat;
    e.port = port;
    e.exp  = v;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_a(input logic en, input logic rst, input logic [1:0] we,
                         input logic [7:0] ad, input logic [15:0] di);
    ENA = en; RSTA = rst; WEA = we; ADDRA = ad; DIA = di;
  endtask

  task automatic drive_b(input logic en, input logic rst, input logic [1:0] we,
                         input logic [7:0] ad, input logic [15:0] di);
    ENB = en; RSTB = rst; WEB = we; ADDRB = ad; DIB = di;
  endtask

  task automatic idle;
    drive_a(1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
    drive_b(1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
  endtask

  int c0;

  initial begin
    RST_N = 1'b0;
    idle();
    tick(); tick();
    n_chk = n_chk + 1;
    if (doa0 !== 16'h00FF) begin
      n_fail = n_fail + 1;
      $display("FAIL direct_reset_doa: got %h, required 00ff", doa0);
    end
    n_chk = n_chk + 1;
    if (dob0 !== 16'h0000) begin
      n_fail = n_fail + 1;
      $display("FAIL direct_reset_dob: got %h, required 0000", dob0);
    end
    n_chk = n_chk + 1;
    if (busy0 !== 1'b1) begin
      n_fail = n_fail + 1;
      $display("FAIL direct_reset_busy: got %b, required 1", busy0);
    end
    n_chk = n_chk + 1;
    if (coll0 !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL direct_reset_coll: got %b, required 0", coll0);
    end
    expect_v(P_DOA,  16'h00FF, 0, "reset_doa");
    expect_v(P_DOB,  16'h0000, 0, "reset_dob");
    expect_v(P_COLL, 16'h0000, 0, "reset_coll");
    expect_v(P_BUSY, 16'h0001, 0, "reset_busy");
    expect_v(P_DOA1, 16'h00FF, 0, "reset_doa_reg");
    tick();

    // Clear sequencer: exactly 256 busy edges.
    RST_N = 1'b1;
    c0 = cyc;
    expect_v(P_BUSY, 16'h0001, 1,   "busy_first");
    expect_v(P_BUSY, 16'h0001, 255, "busy_last");
    expect_v(P_BUSY, 16'h0000, 256, "busy_done");
    repeat (10) tick();
    drive_a(1'b1, 1'b0, 2'b11, 8'h01, 16'hDEAD);
    expect_v(P_DOA, 16'h00FF, 1, "busy_doa_hold");
    tick();
    idle();
    while (cyc < c0 + 256) tick();

    drive_a(1'b1, 1'b0, 2'b00, 8'hFF, 16'h0000);
    drive_b(1'b1, 1'b0, 2'b00, 8'h00, 16'h0000);
    expect_v(P_DOA,  16'h0000, 1, "clr_rd_a_ff");
    expect_v(P_DOB,  16'h0000, 1, "clr_rd_b_00");
    expect_v(P_COLL, 16'h0000, 1, "no_coll_reads");
    expect_v(P_DOA1, 16'h0000, 2, "clr_rd_a_reg");
    tick();
    idle();
    drive_a(1'b1, 1'b0, 2'b00, 8'h01, 16'h0000);
    expect_v(P_DOA, 16'h0000, 1, "busy_write_lost");
    tick();

    // Write-first on A, then cross-port read on B.
    idle();
    drive_a(1'b1, 1'b0, 2'b11, 8'h12, 16'hABCD);
    expect_v(P_DOA, 16'hABCD, 1, "a_write_first");
    tick();
    idle();
    drive_b(1'b1, 1'b0, 2'b00, 8'h12, 16'h0000);
    expect_v(P_DOB, 16'hABCD, 1, "b_read_12");
    tick();

    // Read-first on B with a low-byte write.
    drive_b(1'b1, 1'b0, 2'b01, 8'h12, 16'h5577);
    expect_v(P_DOB, 16'hABCD, 1, "b_read_first");
    tick();
    idle();
    drive_a(1'b1, 1'b0, 2'b00, 8'h12, 16'h0000);
    expect_v(P_DOA, 16'hAB77, 1, "a_read_merged");
    tick();

    // Write-write collision at 0x40.
    drive_a(1'b1, 1'b0, 2'b01, 8'h40, 16'h1111);
    drive_b(1'b1, 1'b0, 2'b11, 8'h40, 16'h2222);
    expect_v(P_COLL, 16'h0001, 1, "coll_ww");
    expect_v(P_DOA,  16'h0011, 1, "coll_a_own_merge");
    expect_v(P_DOB,  16'h0000, 1, "coll_b_old");
    tick();
    drive_a(1'b1, 1'b0, 2'b11, 8'h41, 16'h3333);
    drive_b(1'b1, 1'b0, 2'b00, 8'h42, 16'h0000);
    expect_v(P_COLL, 16'h0000, 1, "coll_diff_addr");
    expect_v(P_DOA,  16'h3333, 1, "indep_a_write");
    expect_v(P_DOB,  16'h0000, 1, "indep_b_read");
    tick();
    drive_a(1'b1, 1'b0, 2'b00, 8'h40, 16'h0000);
    drive_b(1'b1, 1'b0, 2'b00, 8'h41, 16'h0000);
    expect_v(P_DOA, 16'h2211, 1, "coll_mem_merge");
    expect_v(P_DOB, 16'h3333, 1, "indep_mem_41");
    tick();

    // Back-to-back collisions at 0x50.
    drive_a(1'b1, 1'b0, 2'b00, 8'h50, 16'h0000);
    drive_b(1'b1, 1'b0, 2'b11, 8'h50, 16'h1234);
    expect_v(P_COLL, 16'h0001, 1, "coll_b2b_1");
    expect_v(P_DOA,  16'h0000, 1, "coll_reader_old");
    tick();
    drive_a(1'b1, 1'b0, 2'b10, 8'h50, 16'h5678);
    drive_b(1'b1, 1'b0, 2'b00, 8'h50, 16'h0000);
    expect_v(P_COLL, 16'h0001, 1, "coll_b2b_2");
    expect_v(P_DOA,  16'h5634, 1, "coll_a_wf_hi");
    expect_v(P_DOB,  16'h1234, 1, "coll_b_reader_old");
    tick();
    idle();
    drive_a(1'b1, 1'b0, 2'b00, 8'h50, 16'h0000);
    expect_v(P_COLL, 16'h0000, 1, "coll_drop");
    expect_v(P_DOA,  16'h5634, 1, "mem_50");
    tick();

    // Synchronous output reset still writes; output register timing.
    drive_a(1'b1, 1'b1, 2'b11, 8'h05, 16'h3C3C);
    expect_v(P_DOA,  16'h00FF, 1, "rsta_srval");
    expect_v(P_DOA1, 16'h00FF, 1, "rsta_srval_reg");
    tick();
    drive_a(1'b1, 1'b0, 2'b00, 8'h05, 16'h0000);
    expect_v(P_DOA,  16'h3C3C, 1, "rsta_write_kept");
    expect_v(P_DOA1, 16'h00FF, 1, "doreg_not_first");
    expect_v(P_DOA1, 16'h3C3C, 2, "doreg_second");
    tick();
    idle();
    tick();

    // Leave non-reset values on both outputs, then reset mid-clear.
    drive_a(1'b1, 1'b0, 2'b11, 8'hF0, 16'hBEEF);
    drive_b(1'b1, 1'b0, 2'b00, 8'h12, 16'h0000);
    expect_v(P_DOA, 16'hBEEF, 1, "a_write_f0");
    expect_v(P_DOB, 16'hAB77, 1, "b_read_12_again");
    tick();
    idle();
    tick();
    RST_N = 1'b0;
    expect_v(P_DOA,  16'h00FF, 0, "async_doa");
    expect_v(P_DOB,  16'h0000, 0, "async_dob");
    expect_v(P_DOA1, 16'h00FF, 0, "async_doa_reg");
    #1;
    n_chk = n_chk + 1;
    if (doa0 !== 16'h00FF) begin
      n_fail = n_fail + 1;
      $display("FAIL direct_async_doa: got %h, required 00ff", doa0);
    end
    n_chk = n_chk + 1;
    if (doa1 !== 16'h00FF) begin
      n_fail = n_fail + 1;
      $display("FAIL direct_async_doa_reg: got %h, required 00ff", doa1);
    end
    n_chk = n_chk + 1;
    if (dob0 !== 16'h0000) begin
      n_fail = n_fail + 1;
      $display("FAIL direct_async_dob: got %h, required 0000", dob0);
    end
    tick();
    RST_N = 1'b1;
    repeat (100) tick();
    RST_N = 1'b0;
    expect_v(P_BUSY, 16'h0001, 0, "midclr_busy");
    tick();
    RST_N = 1'b1;
    c0 = cyc;
    expect_v(P_BUSY, 16'h0001, 255, "restart_busy_last");
    expect_v(P_BUSY, 16'h0000, 256, "restart_busy_done");
    while (cyc < c0 + 256) tick();
    drive_a(1'b1, 1'b0, 2'b00, 8'hF0, 16'h0000);
    drive_b(1'b1, 1'b0, 2'b00, 8'h05, 16'h0000);
    expect_v(P_DOA, 16'h0000, 1, "restart_clr_f0");
    expect_v(P_DOB, 16'h0000, 1, "restart_clr_05");
    tick();
    idle();
    repeat (4) tick();

    while (q.size() > 0) begin
      n_chk = n_chk + 1;
      n_fail = n_fail + 1;
      $display("FAIL %s: never checked, required %h", q[0].name, q[0].exp);
      q.delete(0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
